// File: rtl/nfu_2_accum.sv
// NFU-2: reduces each row of the NFU-1 product array through a registered adder
// tree, accumulates partial sums across the tiles of a batch and queues saturated results.
module nfu_2_accum #(
  parameter int N      = 16,
  parameter int Tn     = 16,
  parameter int LOG_TN = 4,
  parameter int ACC_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  input  logic                 i_first,
  input  logic                 i_last,
  input  logic [N*Tn*Tn-1:0]   i_products,
  output logic                 o_in_ready,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [N*Tn-1:0]      o_results,
  output logic                 o_overflow
);

  function automatic logic [N-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1:N-1] == {(ACC_W-N+1){v[ACC_W-1]}}) return v[N-1:0];
    else if (v[ACC_W-1])                             return {1'b1, {(N-1){1'b0}}};
    else                                             return {1'b0, {(N-1){1'b1}}};
  endfunction

  // Control flags per stage: index 0 is the input register, LOG_TN the tree output.
  logic [LOG_TN:0]      r_vld;
  logic [LOG_TN:0]      r_first;
  logic [LOG_TN:0]      r_last;
  logic [N*Tn*Tn-1:0]   r_prod_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_first <= '0;
      r_last  <= '0;
    end else begin
      r_vld   <= {r_vld[LOG_TN-1:0],   i_valid};
      r_first <= {r_first[LOG_TN-1:0], i_first};
      r_last  <= {r_last[LOG_TN-1:0],  i_last};
    end
  end

  always_ff @(posedge clk) begin
    r_prod_p0 <= i_products;
  end

  // Stage p1..pLOG_TN: level k holds Tn>>k sums per row, one bit wider than level k-1.
  for (genvar k = 1; k <= LOG_TN; k++) begin : g_lvl
    for (genvar i = 0; i < Tn; i++) begin : g_row
      for (genvar j = 0; j < (Tn >> k); j++) begin : g_node
        logic signed [N+k-2:0] w_a;
        logic signed [N+k-2:0] w_b;
        logic signed [N+k-1:0] r_sum;
        if (k == 1) begin : g_leaf
          assign w_a = r_prod_p0[(i*Tn+2*j)*N +: N];
          assign w_b = r_prod_p0[(i*Tn+2*j+1)*N +: N];
        end else begin : g_inner
          assign w_a = g_lvl[k-1].g_row[i].g_node[2*j].r_sum;
          assign w_b = g_lvl[k-1].g_row[i].g_node[2*j+1].r_sum;
        end
        always_ff @(posedge clk) begin
          r_sum <= {w_a[N+k-2], w_a} + {w_b[N+k-2], w_b};
        end
      end
    end
  end

  // Accumulate stage: first restarts the batch, otherwise add onto the running sum.
  logic [N*Tn-1:0] w_sat;

  for (genvar i = 0; i < Tn; i++) begin : g_acc
    logic signed [N+LOG_TN-1:0] w_tree;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic signed [ACC_W-1:0]    r_acc;

    assign w_tree     = g_lvl[LOG_TN].g_row[i].g_node[0].r_sum;
    assign w_sum      = {{(ACC_W-N-LOG_TN){w_tree[N+LOG_TN-1]}}, w_tree};
    assign w_acc_next = r_first[LOG_TN] ? w_sum : r_acc + w_sum;
    assign w_sat[i*N +: N] = sat(w_acc_next);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              r_acc <= '0;
      else if (r_vld[LOG_TN])  r_acc <= w_acc_next;
    end
  end

  // Two-entry result FIFO; a push into a full FIFO survives only if the head pops.
  logic [N*Tn-1:0] r_mem [2];
  logic            r_wptr;
  logic            r_rptr;
  logic [1:0]      r_count;
  logic            r_overflow;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_wr;

  assign w_push = r_vld[LOG_TN] & r_last[LOG_TN];
  assign w_pop  = o_valid & i_ready;
  assign w_full = (r_count == 2'd2);
  assign w_wr   = w_push & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= ~r_wptr;
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_wr} - {1'b0, w_pop};
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_sat;
  end

  assign o_valid    = (r_count != 2'd0);
  assign o_results  = o_valid ? r_mem[r_rptr] : '0;
  assign o_overflow = r_overflow;

  // Results already queued plus batch-closing tiles still in flight must leave room.
  logic [7:0] w_pend;

  always_comb begin
    w_pend = {6'd0, r_count};
    for (int s = 0; s <= LOG_TN; s++) begin
      w_pend = w_pend + {7'd0, r_vld[s] & r_last[s]};
    end
    o_in_ready = (w_pend < 8'd2);
  end

endmodule
